// File: rtl/io_responder.sv
// io_responder: peripheral side of the CPU's memory-mapped IO port.
// Serves SW/BTN/LED/SEG registers, synchronises and debounces the switch bank
// and confirm button, and drives the LED bank and a 4-digit hex 7-seg display.
// Optional feature macro: IO_SEG_SCAN_EN enables the multiplexed 7-seg scan;
// without it the display is held dark while SEG stays readable/writable.
module io_responder #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SCAN_DIV        = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic [15:0] sw_in,
  input  logic        btn_in,
  output logic [15:0] led_out,
  output logic [3:0]  seg_an,
  output logic [7:0]  seg_cat
);

  localparam logic [7:0] ADDR_SW  = 8'h00;
  localparam logic [7:0] ADDR_BTN = 8'h04;
  localparam logic [7:0] ADDR_LED = 8'h10;
  localparam logic [7:0] ADDR_SEG = 8'h14;

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [15:0]     sw_s1, sw_s2, sw_prev, sw_db;
  logic [DB_W-1:0] sw_cnt;
  logic            btn_s1, btn_s2, btn_prev, btn_db;
  logic [DB_W-1:0] btn_cnt;
  logic            btn_flag;
  logic [15:0]     led_q, seg_q;
  logic            sw_commit, btn_commit, btn_rise, btn_rd;

  // A group commits when its sync value differs from the stable value, has not
  // changed since the previous edge, and has already been held long enough.
  assign sw_commit  = (sw_s2 != sw_db) && (sw_s2 == sw_prev) && (sw_cnt == DB_LAST);
  assign btn_commit = (btn_s2 != btn_db) && (btn_s2 == btn_prev) && (btn_cnt == DB_LAST);
  assign btn_rise   = btn_commit && btn_s2;
  assign btn_rd     = io_read && (addr == ADDR_BTN);

  // Two-flop synchronisers for the asynchronous board inputs.
  always_ff @(posedge clk) begin
    // NOTE: every register uses <= so all flops sample pre-edge values; a
    // blocking '=' here would collapse the two sync stages into one.
    if (!rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      sw_s1  <= sw_in;
      sw_s2  <= sw_s1;
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
    end
  end

  // Switch-group debounce: count consecutive edges of an unchanged new value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_prev <= '0;
      sw_db   <= '0;
      sw_cnt  <= '0;
    end else begin
      sw_prev <= sw_s2;
      if (sw_s2 == sw_db) begin
        sw_cnt <= '0;
      end else if (sw_s2 != sw_prev) begin
        sw_cnt <= DB_W'(1);
      end else if (sw_commit) begin
        sw_db  <= sw_s2;
        sw_cnt <= '0;
      end else begin
        sw_cnt <= sw_cnt + 1'b1;
      end
    end
  end

  // Button debounce, same qualification rule as the switch group.
  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_prev <= 1'b0;
      btn_db   <= 1'b0;
      btn_cnt  <= '0;
    end else begin
      btn_prev <= btn_s2;
      if (btn_s2 == btn_db) begin
        btn_cnt <= '0;
      end else if (btn_s2 != btn_prev) begin
        btn_cnt <= DB_W'(1);
      end else if (btn_commit) begin
        btn_db  <= btn_s2;
        btn_cnt <= '0;
      end else begin
        btn_cnt <= btn_cnt + 1'b1;
      end
    end
  end

  // Sticky press flag: a debounced rising edge beats a simultaneous read-clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_flag <= 1'b0;
    end else if (btn_rise) begin
      btn_flag <= 1'b1;
    end else if (btn_rd) begin
      btn_flag <= 1'b0;
    end
  end

  // CPU-writable LED and SEG registers; other addresses ignore writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      led_q <= '0;
      seg_q <= '0;
    end else if (io_write) begin
      if (addr == ADDR_LED) led_q <= wdata;
      if (addr == ADDR_SEG) seg_q <= wdata;
    end
  end

  // Zero-latency read mux, driven whenever an address is presented.
  always_comb begin
    // NOTE: default first so every path assigns rdata and no latch is inferred.
    rdata = '0;
    case (addr)
      ADDR_SW:  rdata = sw_db;
      ADDR_BTN: rdata = {15'b0, btn_flag};
      ADDR_LED: rdata = led_q;
      ADDR_SEG: rdata = seg_q;
      default:  rdata = '0;
    endcase
  end

  assign led_out = led_q;

`ifdef IO_SEG_SCAN_EN
  localparam int              SC_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);

  logic [SC_W-1:0] scan_cnt;
  logic [1:0]      digit;
  logic [3:0]      nibble;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Digit scan: hold each digit SCAN_DIV cycles, then move to the next one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
    end else if (scan_cnt == SC_LAST) begin
      scan_cnt <= '0;
      digit    <= digit + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Active-low anode select and segment decode for the lit digit, dp off.
  always_comb begin
    nibble  = seg_q[{digit, 2'b00} +: 4];
    seg_an  = ~(4'b0001 << digit);
    seg_cat = {1'b1, hex7(nibble)};
  end
`else
  assign seg_an  = 4'b1111;
  assign seg_cat = 8'hFF;
`endif

endmodule
